// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - Moore FSM control unit for a multicycle ARM-subset datapath
//
// Purpose: sequences fetch/decode/execute for data-processing, LDR/STR and
// branch instructions, with an optional memory wait counter and ARM-style
// conditional execution.
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset; forces all outputs to 0
//   INSTRUCTION  IR contents: cond[31:28] op[27:26] I[25] cmd[24:21] S/L[20]
//   FLAGS        N[3] Z[2] C[1] V[0]
//   A3Src..WD3Src single-bit datapath controls
//   ALUSrcA/ALUSrcB/ResultSrc/RegSrc 2-bit mux selects
//   ALUop        ALU operation code
//   STATE        current state code

module multicycle_control_unit #(
  parameter int MEM_LAT = 0,
  parameter int COND_EN = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] INSTRUCTION,
  input  logic [3:0]  FLAGS,
  output logic        A3Src,
  output logic        AdrSrc,
  output logic        FlagUpdate,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        WD3Src,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  RegSrc,
  output logic [2:0]  ALUop,
  output logic [3:0]  STATE
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [2:0] LAT = MEM_LAT[2:0];

  state_t     state, state_next;
  logic [2:0] cnt, cnt_next;

  logic [3:0] cond;
  logic [1:0] op;
  logic       imm, sl;
  logic [3:0] cmd;
  logic       cond_true;
  logic       unused_bits;

  assign cond        = INSTRUCTION[31:28];
  assign op          = INSTRUCTION[27:26];
  assign imm         = INSTRUCTION[25];
  assign cmd         = INSTRUCTION[24:21];
  assign sl          = INSTRUCTION[20];
  assign unused_bits = ^{INSTRUCTION[19:0], FLAGS[1]};

  always_comb begin
    case (cond)
      4'b0000: cond_true = FLAGS[2];
      4'b0001: cond_true = ~FLAGS[2];
      4'b1010: cond_true = (FLAGS[3] == FLAGS[0]);
      4'b1011: cond_true = (FLAGS[3] != FLAGS[0]);
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
    if (COND_EN == 0) cond_true = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = FETCH;
    cnt_next   = 3'd0;   // zero outside the memory states, so every entry starts at 0
    A3Src      = 1'b0;
    AdrSrc     = 1'b0;
    FlagUpdate = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    WD3Src     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    RegSrc     = 2'b00;
    ALUop      = 3'b000;
    STATE      = state;

    case (state)
      FETCH: begin
        IRWrite    = 1'b1;
        PCWrite    = 1'b1;
        ALUSrcB    = 2'b11;
        ResultSrc  = 2'b10;
        ALUop      = 3'b100;
        state_next = DECODE;
      end
      DECODE: begin
        ALUSrcB   = 2'b11;
        ResultSrc = 2'b10;
        ALUop     = 3'b100;
        if (op == 2'b01)      RegSrc = 2'b10;
        else if (op == 2'b10) RegSrc = 2'b01;
        if (!cond_true) state_next = FETCH;
        else begin
          case (op)
            2'b00:   state_next = imm ? EXECI : EXECR;
            2'b01:   state_next = MEMADR;
            2'b10:   state_next = BRANCH;
            default: state_next = FETCH;
          endcase
        end
      end
      MEMADR: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        ALUop      = 3'b100;
        RegSrc     = 2'b10;
        state_next = sl ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        RegSrc = 2'b10;
        if (cnt == LAT) state_next = MEMWB;
        else begin
          state_next = MEMREAD;
          cnt_next   = cnt + 3'd1;
        end
      end
      MEMWB: begin
        AdrSrc     = 1'b1;
        RegWrite   = 1'b1;
        ResultSrc  = 2'b01;
        RegSrc     = 2'b10;
        state_next = FETCH;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        RegSrc = 2'b10;
        // the store strobe is issued only once the wait cycles have elapsed
        if (cnt == LAT) begin
          MemWrite   = 1'b1;
          state_next = FETCH;
        end else begin
          state_next = MEMWRITE;
          cnt_next   = cnt + 3'd1;
        end
      end
      EXECR, EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = (state == EXECI) ? 2'b01 : 2'b00;
        case (cmd)
          4'b0000:          ALUop = 3'b000;
          4'b1100:          ALUop = 3'b001;
          4'b0010, 4'b1010: ALUop = 3'b010;
          4'b1101:          ALUop = 3'b101;
          default:          ALUop = 3'b100;
        endcase
        FlagUpdate = sl | (cmd == 4'b1010);
        state_next = (cmd == 4'b1010) ? FETCH : ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        ALUSrcA    = 2'b01;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUop      = 3'b100;
        ResultSrc  = 2'b10;
        RegSrc     = 2'b01;
        PCWrite    = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase

    // reset blanks every output immediately, independent of the clock
    if (!reset) begin
      AdrSrc     = 1'b0;
      FlagUpdate = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      RegSrc     = 2'b00;
      ALUop      = 3'b000;
      STATE      = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed self-checking bench for multicycle_control_unit
//
// Purpose: three instances (0: defaults, 1: MEM_LAT=2, 2: COND_EN=0) share
// clock, reset and instruction/flag inputs; each step compares one packed
// control word against a hand-computed value.

module tb_multicycle_control_unit;

  logic        clock;
  logic        reset;
  logic [31:0] instr;
  logic [3:0]  flags;
  logic [22:0] ctl [3];
  int          passed;
  int          failed;
  int          total;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : gi
    logic       a3, adr, fu, irw, mw, pcw, rw, wd3;
    logic [1:0] sa, sb, rs, rg;
    logic [2:0] op;
    logic [3:0] st;
    multicycle_control_unit #(
      .MEM_LAT((g == 1) ? 2 : 0),
      .COND_EN((g == 2) ? 0 : 1)
    ) dut (
      .clock(clock), .reset(reset), .INSTRUCTION(instr), .FLAGS(flags),
      .A3Src(a3), .AdrSrc(adr), .FlagUpdate(fu), .IRWrite(irw),
      .MemWrite(mw), .PCWrite(pcw), .RegWrite(rw), .WD3Src(wd3),
      .ALUSrcA(sa), .ALUSrcB(sb), .ResultSrc(rs), .RegSrc(rg),
      .ALUop(op), .STATE(st)
    );
    assign ctl[g] = {st, op, sa, sb, rs, rg, a3, adr, fu, irw, mw, pcw, rw, wd3};
  end

  // expected word; A3Src and WD3Src are always 0
  function automatic logic [22:0] w(input logic [3:0] st, input logic [2:0] op,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [1:0] rs, input logic [1:0] rg,
                                    input logic adr, input logic fu, input logic irw,
                                    input logic mw, input logic pcw, input logic rw);
    return {st, op, sa, sb, rs, rg, 1'b0, adr, fu, irw, mw, pcw, rw, 1'b0};
  endfunction

  task automatic chk(input string tag, input int g, input logic [22:0] e);
    logic [22:0] got;
    got   = ctl[g];
    total = total + 1;
    assert (got === e) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s inst%0d observed=%h expected=%h", tag, g, got, e);
    end
  endtask

  task automatic start(input logic [31:0] ins, input logic [3:0] fl);
    @(negedge clock);
    reset = 1'b0;
    instr = ins;
    flags = fl;
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  task automatic step;
    @(negedge clock);
  endtask

  logic [22:0] f_w, ldr_dec, memadr_w, memrd_w;

  initial begin
    passed = 0; failed = 0; total = 0;
    reset = 1'b0; instr = 32'h0; flags = 4'h0;
    f_w      = w(4'd0, 3'b100, 2'b00, 2'b11, 2'b10, 2'b00, 0, 0, 1, 0, 1, 0);
    ldr_dec  = w(4'd1, 3'b100, 2'b00, 2'b11, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0);
    memadr_w = w(4'd2, 3'b100, 2'b01, 2'b01, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0);
    memrd_w  = w(4'd3, 3'b000, 2'b00, 2'b00, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clock);
    #1;
    chk("reset_zero", 0, 23'd0);
    chk("reset_zero", 1, 23'd0);
    chk("reset_zero", 2, 23'd0);

    // LDR R1,[R1,#64]
    start(32'hE5911040, 4'h0);
    chk("ldr_fetch", 0, f_w);
    step; chk("ldr_decode", 0, ldr_dec);
    step; chk("ldr_memadr", 0, memadr_w);
    step; chk("ldr_memread", 0, memrd_w);
    step; chk("ldr_memwb", 0, w(4'd4, 3'b000, 2'b00, 2'b00, 2'b01, 2'b10, 1, 0, 0, 0, 0, 1));
    step; chk("ldr_refetch", 0, f_w);

    // ADD R0,R1,R2
    start(32'hE0810002, 4'h0);
    chk("add_fetch", 0, f_w);
    step; chk("add_decode", 0, w(4'd1, 3'b100, 2'b00, 2'b11, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0));
    step; chk("add_execr", 0, w(4'd6, 3'b100, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    step; chk("add_aluwb", 0, w(4'd8, 3'b000, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1));
    step; chk("add_refetch", 0, f_w);

    // STR with MEM_LAT=2 on instance 1; instance 0 stores in a single cycle
    start(32'hE5812041, 4'h0);
    step; chk("str_decode", 1, ldr_dec);
    step; chk("str_memadr", 1, memadr_w);
    step;
    chk("str_memwr0", 1, w(4'd5, 3'b000, 2'b00, 2'b00, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0));
    chk("str_lat0_wr", 0, w(4'd5, 3'b000, 2'b00, 2'b00, 2'b00, 2'b10, 1, 0, 0, 1, 0, 0));
    step; chk("str_memwr1", 1, w(4'd5, 3'b000, 2'b00, 2'b00, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0));
    step; chk("str_memwr2", 1, w(4'd5, 3'b000, 2'b00, 2'b00, 2'b00, 2'b10, 1, 0, 0, 1, 0, 0));
    step; chk("str_refetch", 1, f_w);

    // BEQ taken (Z=1)
    start(32'h0A000002, 4'b0100);
    step; chk("beq_t_decode", 0, w(4'd1, 3'b100, 2'b00, 2'b11, 2'b10, 2'b01, 0, 0, 0, 0, 0, 0));
    step; chk("beq_t_branch", 0, w(4'd9, 3'b100, 2'b10, 2'b01, 2'b10, 2'b01, 0, 0, 0, 0, 1, 0));
    step; chk("beq_t_refetch", 0, f_w);

    // BEQ not taken (Z=0)
    start(32'h0A000002, 4'b0000);
    step; chk("beq_n_decode", 0, w(4'd1, 3'b100, 2'b00, 2'b11, 2'b10, 2'b01, 0, 0, 0, 0, 0, 0));
    step; chk("beq_n_skip", 0, f_w);

    // reset asserted during MEMREAD
    start(32'hE5911040, 4'h0);
    step; step; step;
    chk("abort_memread", 0, memrd_w);
    #2 reset = 1'b0;
    #1 chk("abort_zero", 0, 23'd0);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("abort_fetch", 0, f_w);
    step; chk("abort_decode", 0, ldr_dec);

    // CMP, cond=0000, flags 0: executes only on the COND_EN=0 instance
    start(32'h01510002, 4'h0);
    step;
    chk("cmp_decode", 2, w(4'd1, 3'b100, 2'b00, 2'b11, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0));
    chk("cmp_cond_decode", 0, w(4'd1, 3'b100, 2'b00, 2'b11, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0));
    step;
    chk("cmp_execr", 2, w(4'd6, 3'b010, 2'b10, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0));
    chk("cmp_cond_skip", 0, f_w);
    step; chk("cmp_refetch", 2, f_w);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter MEM_LAT, default 0, extra wait cycles (0..7) held in MEMREAD/MEMWRITE.
REQ-002 Parameter COND_EN, default 1, enables conditional execution on INSTRUCTION[31:28].
REQ-003 clock  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low.
REQ-005 INSTRUCTION  in  32  current IR contents; fields: cond[31:28], op[27:26], I[25], cmd[24:21], S/L[20].
REQ-006 FLAGS  in  4  N[3] Z[2] C[1] V[0] from the datapath flag register.
REQ-007 A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src  out  1 each  datapath controls.
REQ-008 ALUSrcA, ALUSrcB, ResultSrc, RegSrc  out  2 each  datapath mux selects.
REQ-009 ALUop  out  3  ALU operation (AND 000, ORR 001, SUB 010, ADD 100, MOV 101).
REQ-010 STATE  out  4  current state code, for debug/bench.

Function
REQ-011 State codes SHALL be FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9; codes 10-15 SHALL return to FETCH next edge.
REQ-012 Outputs SHALL be Moore (function of state, plus INSTRUCTION/FLAGS where stated); any output not listed for a state SHALL be 0; A3Src and WD3Src SHALL be 0 in every state.
REQ-013 FETCH: IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=11, ResultSrc=10, ALUop=100; next DECODE.
REQ-014 DECODE: ALUSrcB=11, ResultSrc=10, ALUop=100; RegSrc = 10 for op 01, 01 for op 10, else 00.
REQ-015 DECODE transitions: condition false (REQ-022) -> FETCH; op 00 with I=0 -> EXECR; op 00 with I=1 -> EXECI; op 01 -> MEMADR; op 10 -> BRANCH; op 11 -> FETCH.
REQ-016 MEMADR: ALUSrcA=01, ALUSrcB=01, ALUop=100, RegSrc=10; next MEMREAD if L=1, else MEMWRITE.
REQ-017 MEMREAD: AdrSrc=1, RegSrc=10; held MEM_LAT+1 cycles via wait counter, then MEMWB.
REQ-018 MEMWB: AdrSrc=1, RegWrite=1, ResultSrc=01, RegSrc=10; next FETCH.
REQ-019 MEMWRITE: AdrSrc=1, RegSrc=10, held MEM_LAT+1 cycles; MemWrite=1 only in the final held cycle; next FETCH.
REQ-020 EXECR: ALUSrcA=10, ALUSrcB=00; EXECI: ALUSrcA=10, ALUSrcB=01; both: ALUop from cmd (0000 AND, 1100 ORR, 0010 SUB, 1010 SUB, 0100 ADD, 1101 MOV, other ADD); FlagUpdate = S OR (cmd==1010); next ALUWB, except cmd 1010 (CMP) -> FETCH.
REQ-021 ALUWB: RegWrite=1, ALUSrcA=01, ResultSrc=00; next FETCH.
REQ-022 Condition (COND_EN=1): 0000 EQ Z=1; 0001 NE Z=0; 1010 GE N==V; 1011 LT N!=V; 1110 AL true; all other codes false. COND_EN=0: always true.
REQ-023 BRANCH: ALUSrcA=10, ALUSrcB=01, ALUop=100, ResultSrc=10, RegSrc=01, PCWrite=1; next FETCH.
REQ-024 Wait counter SHALL be 3 bits, cleared on every entry to MEMREAD/MEMWRITE; MEM_LAT=0 gives single-cycle memory states.
REQ-025 Instruction cycle counts (MEM_LAT=0): LDR 5, STR 4, data-proc 4, CMP 3, branch 3, skipped/undefined 2.

Reset
REQ-026 While reset=0, state SHALL be FETCH, wait counter 0, and every output including STATE SHALL be forced 0 asynchronously.
REQ-027 First rising edge after reset release SHALL see FETCH outputs and execute the fetch; reset asserted mid-instruction SHALL abort it with no further RegWrite/MemWrite/PCWrite.

Verification
REQ-028 LDR R1,[R1,#64] (0xE5911040), MEM_LAT=0 -> STATE 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01.
REQ-029 ADD R0,R1,R2 (0xE0810002) -> states 0,1,6,8; ALUop=100 in state 6, RegWrite=1 in state 8, FlagUpdate=0 throughout.
REQ-030 STR (0xE5812041), MEM_LAT=2 -> MEMWRITE held 3 cycles, MemWrite=1 only in the third.
REQ-031 BEQ (0x0A000002): FLAGS=0100 -> BRANCH with PCWrite=1; FLAGS=0000 -> DECODE returns to FETCH, no PCWrite after FETCH.
REQ-032 Reset pulled low in MEMREAD -> all outputs 0 immediately; after release STATE=0, IRWrite=1.
REQ-033 CMP with COND_EN=0, cond=0000, FLAGS=0000 -> executes: states 0,1,6,0, FlagUpdate=1, ALUop=010, no RegWrite.
